// File: rtl/div_op_seq_pkg.sv
// Shared definitions for the PDP-11 DIV sequencer: state encoding,
// condition-code bit positions and the quotient value that needs special
// overflow handling.
package div_op_seq_pkg;

  localparam int REG_ADDR_W = 3;

  // Most negative 16-bit quotient; the divider reports it without overflow
  // even when the true result is +32768.
  localparam logic [15:0] DIV_Q_MIN = 16'h8000;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_WR_Q = 3'd2,
    S_WR_R = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // Assemble an NZVC nibble with each flag at its architectural position.
  function automatic logic [3:0] packNzvc(input logic n, input logic z,
                                          input logic v, input logic c);
    logic [3:0] f;
    f       = '0;
    f[CC_N] = n;
    f[CC_Z] = z;
    f[CC_V] = v;
    f[CC_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/div_op_seq_if.sv
// Bundle of every non-clock signal around the DIV sequencer: the request
// from the instruction decoder, the handshake with the 32/16 divider and the
// register-file / condition-code write-back. The sequencer uses the slave
// modport; whoever drives start and models the divider uses master.
interface div_op_seq_if #(parameter int RADDR_W = 3);

  logic               start;
  logic [RADDR_W-1:0] reg_sel;
  logic [31:0]        dividend;
  logic [15:0]        divisor;

  logic               div_ready;
  logic [31:0]        div_dividend;
  logic [15:0]        div_divider;
  logic               div_done;
  logic [15:0]        div_quotient;
  logic [15:0]        div_remainder;
  logic               div_overflow;

  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [15:0]        rf_wdata;
  logic               cc_we;
  logic [3:0]         cc_nzvc;
  logic               busy;
  logic               finished;

  modport slave (
    input  start, reg_sel, dividend, divisor,
    input  div_done, div_quotient, div_remainder, div_overflow,
    output div_ready, div_dividend, div_divider,
    output rf_we, rf_waddr, rf_wdata, cc_we, cc_nzvc, busy, finished
  );

  modport master (
    output start, reg_sel, dividend, divisor,
    output div_done, div_quotient, div_remainder, div_overflow,
    input  div_ready, div_dividend, div_divider,
    input  rf_we, rf_waddr, rf_wdata, cc_we, cc_nzvc, busy, finished
  );

endinterface

// File: rtl/div_op_seq.sv
// PDP-11 DIV sequencer. Latches the operands, traps divide-by-zero, runs the
// ready/done handshake with the external divider, fixes up the divider's
// overflow detection, writes quotient to R and remainder to R|1, and emits
// the NZVC flags together with a one-cycle completion pulse.
module div_op_seq
  import div_op_seq_pkg::*;
#(
  parameter int RADDR_W = REG_ADDR_W
) (
  input logic         clk,
  input logic         reset_n,
  div_op_seq_if.slave bus
);

  state_t             r_state;
  logic [RADDR_W-1:0] r_reg;
  logic [31:0]        r_dividend;
  logic [15:0]        r_divisor;
  logic [15:0]        r_rem;
  logic               r_divReady;
  logic               r_rfWe;
  logic [RADDR_W-1:0] r_rfWaddr;
  logic [15:0]        r_rfWdata;
  logic               r_ccWe;
  logic [3:0]         r_ccNzvc;
  logic               r_busy;
  logic               r_finished;

  logic w_qMinHole;
  logic w_vFlag;

  // A quotient of 0x8000 is only legal when it really means -32768, i.e. the
  // operand signs differ; with equal signs the true result is +32768.
  assign w_qMinHole = (bus.div_quotient == DIV_Q_MIN) &&
                      (r_dividend[31] == r_divisor[15]);
  assign w_vFlag    = bus.div_overflow | w_qMinHole;

  assign bus.div_ready    = r_divReady;
  assign bus.div_dividend = r_dividend;
  assign bus.div_divider  = r_divisor;
  assign bus.rf_we        = r_rfWe;
  assign bus.rf_waddr     = r_rfWaddr;
  assign bus.rf_wdata     = r_rfWdata;
  assign bus.cc_we        = r_ccWe;
  assign bus.cc_nzvc      = r_ccNzvc;
  assign bus.busy         = r_busy;
  assign bus.finished     = r_finished;

  // Sequencer FSM; every output is registered and set on entry to the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_reg      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_divReady <= 1'b0;
      r_rfWe     <= 1'b0;
      r_rfWaddr  <= '0;
      r_rfWdata  <= '0;
      r_ccWe     <= 1'b0;
      r_ccNzvc   <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_rfWe     <= 1'b0;
      r_ccWe     <= 1'b0;
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
            r_reg      <= bus.reg_sel;
            r_busy     <= 1'b1;
            if (bus.divisor == 16'h0000) begin
              r_state    <= S_FIN;
              r_ccNzvc   <= packNzvc(1'b0, 1'b0, 1'b1, 1'b1);
              r_ccWe     <= 1'b1;
              r_finished <= 1'b1;
            end else begin
              r_state    <= S_CALC;
              r_divReady <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (bus.div_done) begin
            r_divReady <= 1'b0;
            r_rem      <= bus.div_remainder;
            if (w_vFlag) begin
              r_state    <= S_FIN;
              r_ccNzvc   <= packNzvc(1'b0, 1'b0, 1'b1, 1'b0);
              r_ccWe     <= 1'b1;
              r_finished <= 1'b1;
            end else begin
              r_ccNzvc  <= packNzvc(bus.div_quotient[15],
                                    bus.div_quotient == 16'h0000, 1'b0, 1'b0);
              r_rfWe    <= 1'b1;
              r_rfWaddr <= r_reg;
              if (r_reg[0]) begin
                r_state   <= S_WR_R;
                r_rfWdata <= bus.div_remainder;
              end else begin
                r_state   <= S_WR_Q;
                r_rfWdata <= bus.div_quotient;
              end
            end
          end
        end
        S_WR_Q: begin
          r_state   <= S_WR_R;
          r_rfWe    <= 1'b1;
          r_rfWaddr <= r_reg | RADDR_W'(1);
          r_rfWdata <= r_rem;
        end
        S_WR_R: begin
          r_state    <= S_FIN;
          r_ccWe     <= 1'b1;
          r_finished <= 1'b1;
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_divReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_op_seq.sv
// Bench for the DIV sequencer: a behavioural 32/16 signed divider answers
// the ready/done handshake, a scoreboard holds the expected register writes
// and flags of each operation, and a vector table plus a few hand-built
// sequences (spurious starts, reset during a divide) drive the DUT.
module tb_div_op_seq;
  import div_op_seq_pkg::*;

  localparam int DIV_LAT = 32;

  typedef struct {
    logic [31:0] dd;
    logic [15:0] dv;
    logic [2:0]  rs;
    logic [15:0] q;
    logic [15:0] r;
    logic [3:0]  nzvc;
    logic        wr;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
  } divRes_t;

  logic clk = 1'b0;
  logic reset_n;

  int nChecks = 0;
  int nFails  = 0;
  int finCount = 0;
  int lastLat = 0;
  logic readySeen = 1'b0;

  wr_t        expWr[$];
  logic [3:0] expCc[$];
  wr_t        monW;

  int          mPhase;
  int          mCnt;
  divRes_t     mRes;
  logic [31:0] mCapDd;
  logic [15:0] mCapDv;

  always #5 clk = ~clk;

  div_op_seq_if #(.RADDR_W(3)) bus ();

  div_op_seq #(.RADDR_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference signed division with the real divider's blind spot: +32768 is not flagged.
  function automatic divRes_t divModel(input logic [31:0] dd, input logic [15:0] dv);
    longint  sd, sv, q, r;
    divRes_t res;
    sd = longint'($signed(dd));
    sv = longint'($signed(dv));
    if (sv == 0) begin
      q = 0;
      r = 0;
    end else begin
      q = sd / sv;
      r = sd % sv;
    end
    res.q   = q[15:0];
    res.r   = r[15:0];
    res.ovf = (q > 32768) || (q < -32768);
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] act);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Divider model: captures on the first ready cycle, answers after DIV_LAT cycles, holds done two cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mPhase            <= 0;
      mCnt              <= 0;
      mCapDd            <= '0;
      mCapDv            <= '0;
      bus.div_done      <= 1'b0;
      bus.div_quotient  <= '0;
      bus.div_remainder <= '0;
      bus.div_overflow  <= 1'b0;
    end else begin
      case (mPhase)
        0: if (bus.div_ready) begin
          mRes   <= divModel(bus.div_dividend, bus.div_divider);
          mCapDd <= bus.div_dividend;
          mCapDv <= bus.div_divider;
          mCnt   <= DIV_LAT;
          mPhase <= 1;
        end
        1: if (mCnt == 0) begin
          bus.div_done      <= 1'b1;
          bus.div_quotient  <= mRes.q;
          bus.div_remainder <= mRes.r;
          bus.div_overflow  <= mRes.ovf;
          mPhase            <= 2;
        end else begin
          mCnt <= mCnt - 1;
        end
        2: mPhase <= 3;
        default: begin
          bus.div_done <= 1'b0;
          mPhase       <= 0;
        end
      endcase
    end
  end

  // Scoreboard monitor: pops expected writes and flags as the DUT produces them.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.div_ready) readySeen = 1'b1;
      if (mPhase == 1 && mCnt == 0) begin
        checkOutput("operand_hold_dividend", bus.div_dividend, mCapDd);
        checkOutput("operand_hold_divisor", {16'h0, bus.div_divider}, {16'h0, mCapDv});
      end
      if (bus.rf_we) begin
        if (expWr.size() == 0) begin
          reportUnexpected("rf_we_unexpected", {13'h0, bus.rf_waddr, bus.rf_wdata});
        end else begin
          monW = expWr.pop_front();
          checkOutput("rf_waddr", {29'h0, bus.rf_waddr}, {29'h0, monW.addr});
          checkOutput("rf_wdata", {16'h0, bus.rf_wdata}, {16'h0, monW.data});
        end
      end
      if (bus.finished || bus.cc_we) begin
        checkOutput("cc_we_with_finished", {31'h0, bus.cc_we}, {31'h0, bus.finished});
        if (expCc.size() == 0) begin
          reportUnexpected("finished_unexpected", {28'h0, bus.cc_nzvc});
        end else begin
          checkOutput("cc_nzvc", {28'h0, bus.cc_nzvc}, {28'h0, expCc.pop_front()});
        end
        finCount++;
      end
    end
  end

  // Runs one DIV from posedge+1 to posedge+1 of the cycle after finished.
  // spurAt > 0 pulses a foreign start that many cycles into the op; spurAt < 0 pulses it during FIN.
  task automatic applyStimulus(input vec_t v, input string tag, input int spurAt);
    int   finBefore;
    int   lat;
    logic done;
    logic spurOn;
    if (v.wr) begin
      if (v.rs[0]) begin
        expWr.push_back('{addr: v.rs, data: v.r});
      end else begin
        expWr.push_back('{addr: v.rs, data: v.q});
        expWr.push_back('{addr: v.rs | 3'd1, data: v.r});
      end
    end
    expCc.push_back(v.nzvc);
    readySeen     = 1'b0;
    finBefore     = finCount;
    bus.start     = 1'b1;
    bus.dividend  = v.dd;
    bus.divisor   = v.dv;
    bus.reg_sel   = v.rs;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput({tag, "_busy_after_start"}, {31'h0, bus.busy}, 32'h1);
    lat    = 0;
    done   = 1'b0;
    spurOn = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (spurOn) begin
        bus.start    = 1'b0;
        bus.dividend = v.dd;
        bus.divisor  = v.dv;
        bus.reg_sel  = v.rs;
        spurOn       = 1'b0;
      end
      if (bus.finished) done = 1'b1;
      if ((spurAt > 0 && lat == spurAt) || (spurAt < 0 && done)) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd5;
        bus.divisor  = 16'd7;
        bus.reg_sel  = 3'd2;
        spurOn       = 1'b1;
      end
    end
    lastLat = lat;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (!done) begin
      reportUnexpected({tag, "_finished_timeout"}, lat);
      expWr.delete();
      expCc.delete();
    end else begin
      checkOutput({tag, "_writes_drained"}, expWr.size(), 0);
      checkOutput({tag, "_cc_drained"}, expCc.size(), 0);
      checkOutput({tag, "_finished_once"}, finCount - finBefore, 1);
      checkOutput({tag, "_div_ready_used"}, {31'h0, readySeen}, {31'h0, (v.dv != 16'h0)});
      checkOutput({tag, "_busy_idle"}, {31'h0, bus.busy}, 32'h0);
    end
  endtask

  vec_t vecs[14];
  int   latNormal;
  int   latOvf;

  initial begin
    // dividend, divisor, R, quotient, remainder, NZVC, writes expected
    vecs[0]  = '{32'd100,       16'd7,     3'd2, 16'h000E, 16'h0002, 4'b0000, 1'b1};
    vecs[1]  = '{32'hFFFFFF9C,  16'd7,     3'd2, 16'hFFF2, 16'hFFFE, 4'b1000, 1'b1};
    vecs[2]  = '{32'd100,       16'd0,     3'd4, 16'h0000, 16'h0000, 4'b0011, 1'b0};
    vecs[3]  = '{32'h00008000,  16'd1,     3'd0, 16'h0000, 16'h0000, 4'b0010, 1'b0};
    vecs[4]  = '{32'h00010000,  16'd1,     3'd0, 16'h0000, 16'h0000, 4'b0010, 1'b0};
    vecs[5]  = '{32'hFFFF8000,  16'd1,     3'd6, 16'h8000, 16'h0000, 4'b1000, 1'b1};
    vecs[6]  = '{32'd5,         16'd7,     3'd2, 16'h0000, 16'h0005, 4'b0100, 1'b1};
    vecs[7]  = '{32'd100,       16'd7,     3'd3, 16'h000E, 16'h0002, 4'b0000, 1'b1};
    vecs[8]  = '{32'd100,       16'hFFF9,  3'd4, 16'hFFF2, 16'h0002, 4'b1000, 1'b1};
    vecs[9]  = '{32'hFFFF8000,  16'hFFFF,  3'd0, 16'h0000, 16'h0000, 4'b0010, 1'b0};
    vecs[10] = '{32'hFFFFFF9C,  16'hFFF9,  3'd0, 16'h000E, 16'hFFFE, 4'b0000, 1'b1};
    vecs[11] = '{32'd0,         16'd5,     3'd6, 16'h0000, 16'h0000, 4'b0100, 1'b1};
    vecs[12] = '{32'h0007FFFF,  16'd16,    3'd2, 16'h7FFF, 16'h000F, 4'b0000, 1'b1};
    vecs[13] = '{32'hFFFF7FFF,  16'd1,     3'd4, 16'h0000, 16'h0000, 4'b0010, 1'b0};

    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.reg_sel  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", {25'h0, bus.busy, bus.div_ready, bus.rf_we, bus.cc_we, bus.finished, bus.rf_waddr}, 32'h0);
    checkOutput("reset_data", {12'h0, bus.cc_nzvc, bus.rf_wdata}, 32'h0);
    checkOutput("reset_dividend", bus.div_dividend, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i), 0);
      if (i == 0) latNormal = lastLat;
      if (i == 2) checkOutput("divzero_latency", lastLat, 1);
      if (i == 3) latOvf = lastLat;
    end
    checkOutput("normal_minus_ovf_latency", latNormal - latOvf, 2);

    $display("[TB] start during CALC is ignored");
    applyStimulus(vecs[0], "spur_calc", 5);

    $display("[TB] start during FIN is ignored");
    applyStimulus(vecs[8], "spur_fin", -1);
    repeat (3) @(negedge clk);
    checkOutput("spur_fin_stays_idle", {31'h0, bus.busy}, 32'h0);
    @(posedge clk);
    #1;

    $display("[TB] reset during CALC");
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 16'd7;
    bus.reg_sel  = 3'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid_calc_ready", {31'h0, bus.div_ready}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {25'h0, bus.busy, bus.div_ready, bus.rf_we, bus.cc_we, bus.finished, bus.rf_waddr}, 32'h0);
    checkOutput("async_reset_dividend", bus.div_dividend, 32'h0);
    checkOutput("async_reset_divisor", {16'h0, bus.div_divider}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(vecs[1], "after_reset", 0);
    applyStimulus(vecs[5], "after_reset2", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
